// File: rtl/text_sequencer_pkg.sv
// rtl/text_sequencer_pkg.sv - shared mode encoding, frame constants and score helpers for the text sequencer
package text_sequencer_pkg;

    localparam int SCORE_W              = 16;
    localparam int BLINK_FRAMES_DEF     = 30;
    localparam int READY_MIN_FRAMES_DEF = 60;
    localparam int GAMEOVER_FRAMES_DEF  = 180;

    typedef enum logic [1:0] {
        GAME_MODE_LOADING   = 2'd0,
        GAME_MODE_READY     = 2'd1,
        GAME_MODE_PLAYING   = 2'd2,
        GAME_MODE_GAME_OVER = 2'd3
    } game_mode_t;

    function automatic logic [SCORE_W-1:0] score_max(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/text_sequencer_frame_timer.sv
// rtl/text_sequencer_frame_timer.sv - 8-bit frame_tick counter with clear, saturate, optional wrap and terminal count
module frame_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       tick,
    input  logic       wrap,
    input  logic [7:0] limit,
    output logic [7:0] count,
    output logic       term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (tick) begin
            if (wrap && (count == limit)) begin
                count <= 8'd0;
            end else if (count != 8'hFF) begin
                count <= count + 8'd1;
            end
        end
    end

    // term qualifies the tick that lands on the limit, so callers act on that edge
    assign term = tick && (count == limit);

endmodule

// File: rtl/text_sequencer.sv
// rtl/text_sequencer.sv - frame-synchronous mode/score/blink sequencer for the text overlay (option: TEXT_SEQ_KEY_SYNC_EN)
module text_sequencer
    import text_sequencer_pkg::*;
#(
    parameter int BLINK_FRAMES     = BLINK_FRAMES_DEF,
    parameter int READY_MIN_FRAMES = READY_MIN_FRAMES_DEF,
    parameter int GAMEOVER_FRAMES  = GAMEOVER_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               load_done,
    input  logic               key_any,
    input  logic               game_over,
    input  logic [SCORE_W-1:0] score_in,
    output game_mode_t         mode,
    output logic [SCORE_W-1:0] score_disp,
    output logic [SCORE_W-1:0] high_score,
    output logic               blink_on,
    output logic               game_start
);

    localparam logic [7:0] BLINK_LIM    = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] READY_MIN    = 8'(READY_MIN_FRAMES);
    localparam logic [7:0] GAMEOVER_LIM = 8'(GAMEOVER_FRAMES - 1);

    logic       key_s;
    logic       key_prev;
    logic       press;
    logic       enter_ready;
    logic       start_play;
    logic       end_game;
    logic       phase_clear;
    logic       phase_tick;
    logic       blink_tick;
    logic [7:0] phase_count;
    logic       phase_term;
    logic [7:0] blink_count_unused;
    logic       blink_term;

`ifdef TEXT_SEQ_KEY_SYNC_EN
    logic [1:0] key_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync <= 2'b00;
        end else begin
            key_sync <= {key_sync[0], key_any};
        end
    end

    assign key_s = key_sync[1];
`else
    assign key_s = key_any;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev <= 1'b0;
        end else begin
            key_prev <= key_s;
        end
    end

    // Edge-only detection means a key held across READY entry never counts as a press
    assign press = key_s && !key_prev;

    always_comb begin
        enter_ready = 1'b0;
        start_play  = 1'b0;
        end_game    = 1'b0;
        phase_tick  = 1'b0;
        blink_tick  = 1'b0;
        case (mode)
            GAME_MODE_LOADING:   enter_ready = frame_tick && load_done;
            GAME_MODE_READY: begin
                start_play = press && (phase_count >= READY_MIN);
                phase_tick = frame_tick;
                blink_tick = frame_tick;
            end
            GAME_MODE_PLAYING:   end_game = game_over;
            GAME_MODE_GAME_OVER: begin
                phase_tick  = frame_tick;
                enter_ready = phase_term;
            end
            default: ;
        endcase
        phase_clear = enter_ready || end_game;
    end

    frame_timer u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (phase_clear),
        .tick  (phase_tick),
        .wrap  (1'b0),
        .limit (GAMEOVER_LIM),
        .count (phase_count),
        .term  (phase_term)
    );

    frame_timer u_blink_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (enter_ready),
        .tick  (blink_tick),
        .wrap  (1'b1),
        .limit (BLINK_LIM),
        .count (blink_count_unused),
        .term  (blink_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= GAME_MODE_LOADING;
            score_disp <= '0;
            high_score <= '0;
            blink_on   <= 1'b1;
            game_start <= 1'b0;
        end else begin
            game_start <= 1'b0;
            case (mode)
                GAME_MODE_LOADING: begin
                    blink_on <= 1'b1;
                    if (enter_ready) begin
                        mode <= GAME_MODE_READY;
                    end
                end
                GAME_MODE_READY: begin
                    if (start_play) begin
                        mode       <= GAME_MODE_PLAYING;
                        game_start <= 1'b1;
                        score_disp <= '0;
                        blink_on   <= 1'b1;
                    end else if (blink_term) begin
                        blink_on <= !blink_on;
                    end
                end
                GAME_MODE_PLAYING: begin
                    blink_on <= 1'b1;
                    // A coincident frame_tick collapses into this single latch
                    if (end_game) begin
                        mode       <= GAME_MODE_GAME_OVER;
                        score_disp <= score_in;
                        high_score <= score_max(high_score, score_in);
                    end else if (frame_tick) begin
                        score_disp <= score_in;
                    end
                end
                GAME_MODE_GAME_OVER: begin
                    blink_on <= 1'b1;
                    if (enter_ready) begin
                        mode <= GAME_MODE_READY;
                    end
                end
                default: begin
                    mode     <= GAME_MODE_LOADING;
                    blink_on <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_sequencer.sv
// tb/tb_text_sequencer.sv - self-checking bench for text_sequencer against a frame-level behavioural model
module tb_text_sequencer;
    import text_sequencer_pkg::*;

    localparam int BLINK    = 2;
    localparam int READYMIN = 4;
    localparam int GOFRAMES = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame_tick = 1'b0;
    logic               load_done = 1'b0;
    logic               key_any = 1'b0;
    logic               game_over = 1'b0;
    logic [SCORE_W-1:0] score_in = '0;
    game_mode_t         mode;
    logic [SCORE_W-1:0] score_disp;
    logic [SCORE_W-1:0] high_score;
    logic               blink_on;
    logic               game_start;

    int checks = 0;
    int errors = 0;

    text_sequencer #(
        .BLINK_FRAMES     (BLINK),
        .READY_MIN_FRAMES (READYMIN),
        .GAMEOVER_FRAMES  (GOFRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .load_done  (load_done),
        .key_any    (key_any),
        .game_over  (game_over),
        .score_in   (score_in),
        .mode       (mode),
        .score_disp (score_disp),
        .high_score (high_score),
        .blink_on   (blink_on),
        .game_start (game_start)
    );

    always #5 clk = ~clk;

    // Model: counts whole frames spent in READY / GAME_OVER; blink is a function of READY frames
    game_mode_t m_mode;
    int         ready_frames;
    int         over_frames;
    int         m_score;
    int         m_high;
    logic       m_start;
    logic       m_key_seen;
    logic       m_key;
`ifdef TEXT_SEQ_KEY_SYNC_EN
    logic       m_k1, m_k2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k1 <= 1'b0;
            m_k2 <= 1'b0;
        end else begin
            m_k1 <= key_any;
            m_k2 <= m_k1;
        end
    end
    assign m_key = m_k2;
`else
    assign m_key = key_any;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode       <= GAME_MODE_LOADING;
            ready_frames <= 0;
            over_frames  <= 0;
            m_score      <= 0;
            m_high       <= 0;
            m_start      <= 1'b0;
            m_key_seen   <= 1'b0;
        end else begin
            m_key_seen <= m_key;
            m_start    <= 1'b0;
            if (m_mode == GAME_MODE_LOADING) begin
                if (frame_tick && load_done) begin
                    m_mode       <= GAME_MODE_READY;
                    ready_frames <= 0;
                end
            end else if (m_mode == GAME_MODE_READY) begin
                if (m_key && !m_key_seen && ready_frames >= READYMIN) begin
                    m_mode  <= GAME_MODE_PLAYING;
                    m_start <= 1'b1;
                    m_score <= 0;
                end else if (frame_tick) begin
                    ready_frames <= ready_frames + 1;
                end
            end else if (m_mode == GAME_MODE_PLAYING) begin
                if (game_over) begin
                    m_mode      <= GAME_MODE_GAME_OVER;
                    m_score     <= int'(score_in);
                    m_high      <= (int'(score_in) > m_high) ? int'(score_in) : m_high;
                    over_frames <= 0;
                end else if (frame_tick) begin
                    m_score <= int'(score_in);
                end
            end else begin
                if (frame_tick) begin
                    if (over_frames + 1 == GOFRAMES) begin
                        m_mode       <= GAME_MODE_READY;
                        ready_frames <= 0;
                    end else begin
                        over_frames <= over_frames + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic compare_model();
        logic exp_blink;
        exp_blink = (m_mode != GAME_MODE_READY) || (((ready_frames / BLINK) % 2) == 0);
        chk("mdl_mode", 32'(mode), 32'(m_mode));
        chk("mdl_score_disp", 32'(score_disp), 32'(m_score));
        chk("mdl_high_score", 32'(high_score), 32'(m_high));
        chk("mdl_blink_on", 32'(blink_on), 32'(exp_blink));
        chk("mdl_game_start", 32'(game_start), 32'(m_start));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_model();
        end
    endtask

    task automatic tick_pulse();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic press_key();
        key_any = 1'b1;
        cyc(1);
    endtask

    task automatic ready_to_playing();
        key_any = 1'b0;
        for (int i = 0; i < READYMIN; i++) tick_pulse();
        press_key();
        chk("start_mode", 32'(mode), 32'(GAME_MODE_PLAYING));
        key_any = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        chk("rst_mode", 32'(mode), 32'(GAME_MODE_LOADING));
        chk("rst_blink", 32'(blink_on), 32'd1);
        chk("rst_score", 32'(score_disp), 32'd0);
        chk("rst_start", 32'(game_start), 32'd0);
        rst_n = 1'b1;
        load_done = 1'b1;
        cyc(100);
        chk("load_no_tick", 32'(mode), 32'(GAME_MODE_LOADING));
        tick_pulse();
        chk("load_to_ready", 32'(mode), 32'(GAME_MODE_READY));
        chk("ready_blink", 32'(blink_on), 32'd1);

        tick_pulse();
        tick_pulse();
        chk("blink_tick2", 32'(blink_on), 32'd0);
        press_key();
        cyc(1);
        key_any = 1'b0;
        cyc(2);
        chk("early_press", 32'(mode), 32'(GAME_MODE_READY));
        tick_pulse();
        chk("blink_tick3", 32'(blink_on), 32'd0);
        tick_pulse();
        chk("blink_tick4", 32'(blink_on), 32'd1);
        press_key();
        chk("press_mode", 32'(mode), 32'(GAME_MODE_PLAYING));
        chk("press_start", 32'(game_start), 32'd1);
        cyc(1);
        chk("start_single", 32'(game_start), 32'd0);
        key_any = 1'b0;

        score_in = 16'd10;
        tick_pulse();
        chk("score_10", 32'(score_disp), 32'd10);
        score_in = 16'd20;
        cyc(3);
        chk("score_hold", 32'(score_disp), 32'd10);
        tick_pulse();
        chk("score_20", 32'(score_disp), 32'd20);

        score_in = 16'd1234;
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        chk("go_mode", 32'(mode), 32'(GAME_MODE_GAME_OVER));
        chk("go_score", 32'(score_disp), 32'd1234);
        chk("go_high", 32'(high_score), 32'd1234);
        press_key();
        key_any = 1'b0;
        tick_pulse();
        press_key();
        key_any = 1'b0;
        tick_pulse();
        chk("go_keys", 32'(mode), 32'(GAME_MODE_GAME_OVER));
        tick_pulse();
        chk("go_to_ready", 32'(mode), 32'(GAME_MODE_READY));
        chk("go_ready_blink", 32'(blink_on), 32'd1);
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        chk("go_ignored", 32'(mode), 32'(GAME_MODE_READY));

        ready_to_playing();
        score_in = 16'd500;
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        chk("high_keep", 32'(high_score), 32'd1234);
        chk("score_500", 32'(score_disp), 32'd500);
        for (int i = 0; i < GOFRAMES; i++) tick_pulse();
        ready_to_playing();
        score_in = 16'hFFFF;
        game_over = 1'b1;
        frame_tick = 1'b1;
        cyc(1);
        game_over = 1'b0;
        frame_tick = 1'b0;
        chk("high_max", 32'(high_score), 32'hFFFF);
        chk("score_max", 32'(score_disp), 32'hFFFF);
        chk("tick_go_mode", 32'(mode), 32'(GAME_MODE_GAME_OVER));
        cyc(2);

        rst_n = 1'b0;
        key_any = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        tick_pulse();
        for (int i = 0; i < READYMIN + 2; i++) tick_pulse();
        chk("held_key", 32'(mode), 32'(GAME_MODE_READY));
        key_any = 1'b0;
        cyc(2);
        press_key();
        chk("held_release", 32'(mode), 32'(GAME_MODE_PLAYING));
        key_any = 1'b0;
        score_in = 16'd77;
        tick_pulse();
        chk("score_77", 32'(score_disp), 32'd77);

        #1;
        rst_n = 1'b0;
        #1;
        chk("async_mode", 32'(mode), 32'(GAME_MODE_LOADING));
        chk("async_score", 32'(score_disp), 32'd0);
        chk("async_high", 32'(high_score), 32'd0);
        chk("async_blink", 32'(blink_on), 32'd1);
        chk("async_start", 32'(game_start), 32'd0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
